// File: rtl/gpu_pkg.sv
// Shared geometry and writer FSM encoding for the VRAM pixel path.
// Combinational constants only; no latency or backpressure of its own.
package gpu_pkg;
    localparam int ROWS      = 64;
    localparam int COLS      = 64;
    localparam int PIX_W_DEF = 8;
    localparam int ROW_W     = COLS * PIX_W_DEF;
    localparam int COORD_W   = $clog2(ROWS);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RD,
        READ,
        MERGE,
        WAIT_WR,
        WRITE
    } state_t;
endpackage

// File: rtl/pixel_fifo.sv
// Pixel request queue: head visible same cycle, one-cycle write-to-empty-deassert latency.
// Push while full is dropped; full/empty are registered from the post-edge count.
module pixel_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage needs no reset: pointers and flags define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/vram_pixel_writer.sv
// Queues pixel writes and applies them as read-merge-write of 64-pixel VRAM rows.
// Push-to-write 6 cycles uncontended; out_READY drops when the queue is full.
module vram_pixel_writer
    import gpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PIX_W      = PIX_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_WR,
    input  logic [COORD_W-1:0]      in_X,
    input  logic [COORD_W-1:0]      in_Y,
    input  logic [PIX_W-1:0]        in_COLOR,
    output logic                    out_READY,
    output logic                    out_BUSY,
    input  logic                    in_VRAM_AVAILABLE,
    output logic [COORD_W-1:0]      out_ADDR,
    output logic                    out_RD,
    input  logic [COLS*PIX_W-1:0]   in_data,
    input  logic                    in_VRAM_SIGNAL,
    output logic                    out_WE,
    output logic [COLS*PIX_W-1:0]   out_data
);
    localparam int ENT_W     = 2 * COORD_W + PIX_W;
    localparam int MERGE_MAX = FIFO_DEPTH + 4;
    localparam int MC_W      = $clog2(MERGE_MAX + 1);

    state_t                 state;
    logic [COLS*PIX_W-1:0]  row_buf;
    logic [MC_W-1:0]        merge_cnt;
    logic                   push;
    logic                   pop;
    logic                   q_full;
    logic                   q_empty;
    logic [ENT_W-1:0]       head;
    logic [COORD_W-1:0]     head_x;
    logic [COORD_W-1:0]     head_y;
    logic [PIX_W-1:0]       head_color;
    logic                   merge_hit;

    assign push      = in_WR && out_READY;
    assign out_READY = !q_full;
    assign {head_x, head_y, head_color} = head;

    // out_ADDR doubles as the current-row register for the whole transaction.
    assign merge_hit = (state == MERGE) && !q_empty && (head_y == out_ADDR)
                       && (merge_cnt != MC_W'(MERGE_MAX));
    assign pop       = merge_hit;

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat ({in_X, in_Y, in_COLOR}),
        .pop      (pop),
        .head_dat (head),
        .full     (q_full),
        .empty    (q_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_ADDR  <= '0;
            out_RD    <= 1'b0;
            out_WE    <= 1'b0;
            out_BUSY  <= 1'b0;
            out_data  <= '0;
            row_buf   <= '0;
            merge_cnt <= '0;
        end else begin
            out_WE   <= 1'b0;
            out_BUSY <= 1'b1;
            case (state)
                IDLE: begin
                    if (!q_empty) begin
                        state    <= WAIT_RD;
                        out_ADDR <= head_y;
                    end else begin
                        out_BUSY <= push;
                    end
                end
                WAIT_RD: begin
                    if (in_VRAM_AVAILABLE) begin
                        state  <= READ;
                        out_RD <= 1'b1;
                    end
                end
                // Once issued the read must finish; availability is not consulted here.
                READ: begin
                    if (in_VRAM_SIGNAL) begin
                        row_buf   <= in_data;
                        out_RD    <= 1'b0;
                        merge_cnt <= '0;
                        state     <= MERGE;
                    end
                end
                MERGE: begin
                    if (merge_hit) begin
                        row_buf[int'(head_x)*PIX_W +: PIX_W] <= head_color;
                        merge_cnt <= merge_cnt + 1'b1;
                    end else begin
                        state <= WAIT_WR;
                    end
                end
                WAIT_WR: begin
                    if (in_VRAM_AVAILABLE) begin
                        state    <= WRITE;
                        out_WE   <= 1'b1;
                        out_data <= row_buf;
                    end
                end
                WRITE: begin
                    state    <= IDLE;
                    out_BUSY <= push || !q_empty;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vram_pixel_writer.sv
// Directed bench: a 64-row golden image plus a bench-side VRAM model check every row write.
module tb_vram_pixel_writer;
    localparam int RW = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_WR;
    logic [5:0]    in_X;
    logic [5:0]    in_Y;
    logic [7:0]    in_COLOR;
    logic          out_READY;
    logic          out_BUSY;
    logic          in_VRAM_AVAILABLE;
    logic [5:0]    out_ADDR;
    logic          out_RD;
    logic [RW-1:0] in_data = '0;
    logic          in_VRAM_SIGNAL = 1'b0;
    logic          out_WE;
    logic [RW-1:0] out_data;

    vram_pixel_writer #(.FIFO_DEPTH(4), .PIX_W(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_WR             (in_WR),
        .in_X              (in_X),
        .in_Y              (in_Y),
        .in_COLOR          (in_COLOR),
        .out_READY         (out_READY),
        .out_BUSY          (out_BUSY),
        .in_VRAM_AVAILABLE (in_VRAM_AVAILABLE),
        .out_ADDR          (out_ADDR),
        .out_RD            (out_RD),
        .in_data           (in_data),
        .in_VRAM_SIGNAL    (in_VRAM_SIGNAL),
        .out_WE            (out_WE),
        .out_data          (out_data)
    );

    always #5 clk = ~clk;

    logic [RW-1:0] vram [64];
    logic [RW-1:0] gold [64];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            rd_count = 0;
    int            wr_count = 0;
    int            acc_count = 0;
    int            push_cyc = 0;
    int            rd_rise_cyc = 0;
    int            last_we_cyc = 0;
    int            mem_delay = 0;
    int            mem_wait = 0;
    logic          inject_sig = 1'b0;
    logic          prev_we = 1'b0;
    logic          prev_rd = 1'b0;
    logic [RW-1:0] last_we_data = '0;
    logic [5:0]    last_we_addr = '0;

    always @(posedge clk) cyc++;

    // VRAM model: answers a pending read after mem_delay idle cycles with the stored row.
    always @(negedge clk) begin
        if (rst || !out_RD || in_VRAM_SIGNAL) begin
            mem_wait       = 0;
            in_VRAM_SIGNAL = inject_sig;
        end else if (mem_wait >= mem_delay) begin
            in_VRAM_SIGNAL = 1'b1;
            in_data        = vram[out_ADDR];
            rd_count++;
            mem_wait       = 0;
        end else begin
            mem_wait++;
            in_VRAM_SIGNAL = inject_sig;
        end
    end

    // Every row write must match the golden image and be a lone one-cycle strobe.
    always @(negedge clk) begin
        if (out_WE === 1'b1) begin
            checks++;
            if (out_data !== gold[out_ADDR]) begin
                errors++;
                $display("FAIL row_write addr=%0d got=%h want=%h", out_ADDR, out_data, gold[out_ADDR]);
            end
            checks++;
            if (prev_we === 1'b1 || out_RD !== 1'b0) begin
                errors++;
                $display("FAIL we_strobe prev_we=%b rd=%b required prev_we=0 rd=0", prev_we, out_RD);
            end
            vram[out_ADDR] = out_data;
            wr_count++;
            last_we_cyc  = cyc;
            last_we_data = out_data;
            last_we_addr = out_ADDR;
        end
        if (out_RD === 1'b1 && prev_rd !== 1'b1) rd_rise_cyc = cyc;
        prev_we = out_WE;
        prev_rd = out_RD;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_int(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, exp);
        end
    endtask

    task automatic chk_row(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic push(input logic [5:0] x, input logic [5:0] y, input logic [7:0] c);
        in_WR    = 1'b1;
        in_X     = x;
        in_Y     = y;
        in_COLOR = c;
        if (out_READY === 1'b1) begin
            gold[y][int'(x)*8 +: 8] = c;
            acc_count++;
        end
        push_cyc = cyc + 1;
        step();
        in_WR = 1'b0;
    endtask

    task automatic wait_wr(input int target, input int budget, input string name);
        int k = 0;
        while (wr_count < target && k < budget) begin
            step();
            k++;
        end
        chk_int(name, 32'(wr_count >= target), 1);
    endtask

    task automatic wait_rd(input int budget, input string name);
        int k = 0;
        while (out_RD !== 1'b1 && k < budget) begin
            step();
            k++;
        end
        chk_int(name, 32'(out_RD), 1);
    endtask

    initial begin
        logic [RW-1:0] lit;
        int base_wr;
        int base_rd;
        int rd_high;

        in_WR = 1'b0; in_X = '0; in_Y = '0; in_COLOR = '0;
        in_VRAM_AVAILABLE = 1'b1;
        for (int i = 0; i < 64; i++) begin
            vram[i] = '0;
            gold[i] = '0;
        end
        repeat (3) step();
        chk_int("rst_ready", 32'(out_READY), 1);
        chk_int("rst_busy", 32'(out_BUSY), 0);
        chk_int("rst_rd", 32'(out_RD), 0);
        chk_int("rst_we", 32'(out_WE), 0);
        chk_int("rst_addr", 32'(out_ADDR), 0);
        chk_row("rst_data", out_data, '0);
        rst = 1'b0;
        step();

        // Single pixel, uncontended latency.
        base_wr = wr_count; base_rd = rd_count;
        push(6'd5, 6'd10, 8'hA5);
        wait_wr(base_wr + 1, 40, "t1_write_seen");
        chk_int("t1_rd_rise", rd_rise_cyc - push_cyc, 2);
        chk_int("t1_we_cycle", last_we_cyc - push_cyc, 6);
        chk_int("t1_we_addr", 32'(last_we_addr), 10);
        lit = '0; lit[47:40] = 8'hA5;
        chk_row("t1_we_data", last_we_data, lit);
        repeat (3) step();
        chk_int("t1_reads", rd_count - base_rd, 1);
        chk_int("t1_idle_busy", 32'(out_BUSY), 0);
        chk_row("t1_data_held", out_data, lit);

        // Coalescing three pixels of one row.
        base_wr = wr_count; base_rd = rd_count;
        push(6'd1, 6'd3, 8'h11);
        push(6'd2, 6'd3, 8'h22);
        push(6'd3, 6'd3, 8'h33);
        wait_wr(base_wr + 1, 40, "t2_write_seen");
        repeat (10) step();
        lit = '0; lit[31:0] = 32'h3322_1100;
        chk_row("t2_we_data", last_we_data, lit);
        chk_int("t2_we_addr", 32'(last_we_addr), 3);
        chk_int("t2_reads", rd_count - base_rd, 1);
        chk_int("t2_writes", wr_count - base_wr, 1);

        // Same-pixel overwrite keeps queue order.
        base_wr = wr_count;
        push(6'd7, 6'd4, 8'h01);
        push(6'd7, 6'd4, 8'hFF);
        wait_wr(base_wr + 1, 40, "t3_write_seen");
        repeat (10) step();
        lit = '0; lit[63:56] = 8'hFF;
        chk_row("t3_we_data", last_we_data, lit);
        chk_int("t3_writes", wr_count - base_wr, 1);

        // Display holds VRAM: no read may start.
        base_wr = wr_count;
        in_VRAM_AVAILABLE = 1'b0;
        push(6'd0, 6'd12, 8'h5A);
        rd_high = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_RD !== 1'b0) rd_high++;
        end
        chk_int("t4_rd_held_off", rd_high, 0);
        chk_int("t4_busy", 32'(out_BUSY), 1);
        in_VRAM_AVAILABLE = 1'b1;
        step();
        chk_int("t4_rd_next_cycle", 32'(out_RD), 1);
        wait_wr(base_wr + 1, 40, "t4_write_seen");
        repeat (3) step();

        // Availability drops mid-read: read completes, write waits.
        base_wr = wr_count; base_rd = rd_count;
        mem_delay = 4;
        push(6'd63, 6'd13, 8'h3C);
        wait_rd(20, "t5_rd_seen");
        in_VRAM_AVAILABLE = 1'b0;
        repeat (12) step();
        chk_int("t5_read_done", rd_count - base_rd, 1);
        chk_int("t5_rd_low", 32'(out_RD), 0);
        chk_int("t5_no_write", wr_count - base_wr, 0);
        chk_int("t5_busy", 32'(out_BUSY), 1);
        in_VRAM_AVAILABLE = 1'b1;
        wait_wr(base_wr + 1, 10, "t5_write_seen");
        lit = '0; lit[511:504] = 8'h3C;
        chk_row("t5_we_data", last_we_data, lit);
        mem_delay = 0;
        repeat (3) step();

        // Full queue: fifth request dropped.
        base_wr = wr_count;
        acc_count = 0;
        in_VRAM_AVAILABLE = 1'b0;
        for (int i = 0; i < 5; i++) push(6'(i), 6'(20 + i), 8'(8'h10 + i));
        chk_int("t6_accepted", acc_count, 4);
        chk_int("t6_ready_low", 32'(out_READY), 0);
        in_VRAM_AVAILABLE = 1'b1;
        wait_wr(base_wr + 4, 200, "t6_writes_seen");
        repeat (20) step();
        chk_int("t6_writes", wr_count - base_wr, 4);
        chk_row("t6_row24_untouched", vram[24], '0);
        lit = '0; lit[31:24] = 8'h13;
        chk_row("t6_row23", vram[23], lit);
        chk_int("t6_ready_back", 32'(out_READY), 1);

        // Reset while a read is outstanding.
        base_wr = wr_count;
        mem_delay = 50;
        push(6'd9, 6'd30, 8'h77);
        wait_rd(20, "t7_rd_seen");
        rst = 1'b1;
        step();
        chk_int("t7_rd_dropped", 32'(out_RD), 0);
        chk_int("t7_we", 32'(out_WE), 0);
        chk_int("t7_ready", 32'(out_READY), 1);
        chk_int("t7_busy", 32'(out_BUSY), 0);
        chk_int("t7_addr", 32'(out_ADDR), 0);
        chk_row("t7_data_cleared", out_data, '0);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) gold[i] = vram[i];
        mem_delay = 0;
        inject_sig = 1'b1;
        step();
        inject_sig = 1'b0;
        repeat (20) step();
        chk_int("t7_no_write", wr_count - base_wr, 0);
        chk_int("t7_idle_busy", 32'(out_BUSY), 0);

        // Normal operation resumes on the abandoned row.
        base_wr = wr_count;
        push(6'd1, 6'd30, 8'h42);
        wait_wr(base_wr + 1, 40, "t8_write_seen");
        lit = '0; lit[15:8] = 8'h42;
        chk_row("t8_we_data", last_we_data, lit);
        repeat (5) step();

        for (int i = 0; i < 64; i++) chk_row($sformatf("final_row%0d", i), vram[i], gold[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout cyc=%0d required completion", cyc);
        $fatal(1);
    end
endmodule

// File: doc/vram_pixel_writer.md
VRAM_PIXEL_WRITER -- requirements
Module: vram_pixel_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, pixel-request queue depth; power of two, 2..16.
REQ-002 Parameter PIX_W, default 8, bits per pixel; 64 pixels per row word, so the row word is 64*PIX_W = 512 bits.
REQ-003 clk  in  1  single clock; all logic on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_WR  in  1  pixel write request, accepted when high in the same cycle as out_READY.
REQ-006 in_X  in  6  pixel column 0..63.
REQ-007 in_Y  in  6  pixel row 0..63 (VRAM word address).
REQ-008 in_COLOR  in  PIX_W  pixel value.
REQ-009 out_READY  out  1  queue not full.
REQ-010 out_BUSY  out  1  queue non-empty or FSM not in IDLE.
REQ-011 in_VRAM_AVAILABLE  in  1  display side is not using VRAM; grants the start of an access.
REQ-012 out_ADDR  out  6  VRAM row address.
REQ-013 out_RD  out  1  row read request, level, held until done.
REQ-014 in_data  in  512  read row word, valid in the cycle in_VRAM_SIGNAL is high.
REQ-015 in_VRAM_SIGNAL  in  1  read-done pulse.
REQ-016 out_WE  out  1  one-cycle row write strobe.
REQ-017 out_data  out  512  row word written with out_WE.

Function
REQ-018 Request queue: FIFO of {X,Y,COLOR}; push = in_WR & out_READY; in_WR while full is ignored, with no side effects.
REQ-019 Simultaneous push and pop while full: the pop frees the slot, but out_READY stays low that cycle; it is registered and reflects the count after the edge.
REQ-020 FSM states: IDLE, WAIT_RD, READ, MERGE, WAIT_WR, WRITE.
REQ-021 IDLE -> WAIT_RD when the queue is non-empty; the head Y is latched as the current row and out_ADDR is driven from it.
REQ-022 WAIT_RD -> READ on the first cycle in_VRAM_AVAILABLE=1; out_RD rises the cycle after.
REQ-023 READ: hold out_RD=1 and out_ADDR stable until in_VRAM_SIGNAL=1.
REQ-024 READ completion: on in_VRAM_SIGNAL=1, latch in_data into the row buffer, drop out_RD next cycle, and go to MERGE.
REQ-025 A read once issued always completes; in_VRAM_AVAILABLE falling during READ is ignored.
REQ-026 MERGE: each cycle, if the queue head Y equals the current row, pop it and write COLOR into buffer bits [PIX_W*X+PIX_W-1 : PIX_W*X].
REQ-027 MERGE exit: otherwise (head row differs or queue empty) -> WAIT_WR; at least one entry is always merged.
REQ-028 Same-pixel ordering: later entries for the same pixel overwrite earlier ones (queue order).
REQ-029 MERGE coalescing bound: at most FIFO_DEPTH+4 merges per row, then forced exit, so a continuous stream of same-row pushes cannot starve the write.
REQ-030 WAIT_WR -> WRITE when in_VRAM_AVAILABLE=1.
REQ-031 WRITE: out_WE=1 for exactly one cycle with out_ADDR = current row and out_data = buffer; then IDLE.
REQ-032 Latency, uncontended (AVAILABLE=1, memory done 1 cycle after RD, single entry): push at cycle 0 -> out_WE at cycle 6.
REQ-033 Output defaults: out_RD and out_WE are 0 outside READ/WRITE.
REQ-034 Output defaults: out_data is held from the last write.
REQ-035 out_BUSY is registered.

Reset
REQ-036 On rst: FSM to IDLE, queue emptied, row buffer and out_data cleared to 0.
REQ-037 On rst: out_ADDR=0, out_RD=0, out_WE=0, out_BUSY=0, out_READY=1 from the first cycle after the reset edge.
REQ-038 Reset mid-READ or mid-WAIT_WR abandons the transaction: no out_WE, queued pixels lost; an in_VRAM_SIGNAL arriving after reset is ignored.

Structure
REQ-039 gpu_pkg holds ROWS=64, COLS=64, PIX_W default, ROW_W=512 and the FSM state encoding.
REQ-040 Sub-module pixel_fifo (parameterised depth/width, registered full/empty, synchronous reset) implements the queue.

Verification
REQ-041 Single pixel: reset, memory returns all-zero rows; push X=5,Y=10,COLOR=8'hA5 -> out_RD with ADDR=10, then out_WE with ADDR=10, out_data bits[47:40]=A5, all other bits 0, at cycle 6.
REQ-042 Coalescing: push (1,3,11),(2,3,22),(3,3,33) back-to-back -> one read and one write of row 3 carrying bytes 11,22,33 at columns 1..3.
REQ-043 Overwrite: push (7,4,01) then (7,4,FF) -> a single write with byte 7 = FF.
REQ-044 Contention: hold in_VRAM_AVAILABLE=0 for 20 cycles after a push -> out_RD stays 0; AVAILABLE=1 -> RD next cycle.
REQ-044a Contention mid-read: drop AVAILABLE during READ -> the read completes, and WAIT_WR stalls until AVAILABLE returns.
REQ-045 Full queue: with AVAILABLE=0, push 5 entries at depth 4 -> out_READY low after 4, fifth ignored; on release, exactly 4 pixels reach VRAM.
REQ-046 Reset: assert rst while out_RD=1 -> RD low next cycle, no out_WE, out_READY=1, out_BUSY=0.
